trdb_packet_emitter: RTL and testbench

// Output stage directly downstream of the trace debugger's packet generator.
// - Accepts variable-length trace packets (1..PKT_W bits), rounds each up to whole bytes and packs them densely, little-endian, into fixed-width words.
// - Emits the words on a valid/ready stream that feeds the trace sink (FIFO/APB readout).
// - A flush request drains any partial word, zero-padded.

---
 rtl/trdb_pkg.sv | 24 ++
 rtl/trdb_packet_emitter.sv | 110 +++++++++++
 tb/tb_trdb_packet_emitter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
`default_nettype none
// ============================================================
// trdb_pkg: shared defaults and length helpers for the trace emitter.
// Rev 1.0
// ============================================================
package trdb_pkg;

  localparam int TRDB_PKT_W  = 128;
  localparam int TRDB_WORD_W = 32;

  function automatic int len2bytes(input int len);
    return (len + 7) / 8;
  endfunction

  // Keeps only the valid low bits of the final byte of a packet.
  function automatic logic [7:0] lastbyte_mask(input int len);
    int rem;
    rem = len % 8;
    if (rem == 0) return 8'hFF;
    return 8'((1 << rem) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trdb_packet_emitter.sv
`default_nettype none
// ============================================================
// trdb_packet_emitter: packs byte-rounded trace packets into words.
// Rev 1.0
// ============================================================
module trdb_packet_emitter
  import trdb_pkg::*;
#(
  parameter int PKT_W  = TRDB_PKT_W,
  parameter int WORD_W = TRDB_WORD_W,
  parameter int LEN_W  = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [PKT_W-1:0]                          packet_i,
  input  logic [LEN_W-1:0]                          packet_len_i,
  input  logic                                      packet_valid_i,
  output logic                                      packet_ready_o,
  input  logic                                      flush_i,
  output logic [WORD_W-1:0]                         word_o,
  output logic                                      word_valid_o,
  input  logic                                      word_ready_i,
  output logic [$clog2(PKT_W/8+WORD_W/8+1)-1:0]     fill_bytes_o
);

  localparam int PKT_B  = PKT_W / 8;
  localparam int WB     = WORD_W / 8;
  localparam int BUF_B  = PKT_B + WB;
  localparam int BUF_W  = BUF_B * 8;
  localparam int FILL_W = $clog2(BUF_B + 1);

  localparam logic [FILL_W-1:0] C_WB        = FILL_W'(WB);
  localparam logic [FILL_W-1:0] C_READY_MAX = FILL_W'(BUF_B - PKT_B);

  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic              r_flush_pend;

  logic              w_ready;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [WORD_W-1:0] w_word;
  int                w_nbytes;
  logic [7:0]        w_lmask;
  logic [PKT_W-1:0]  w_pkt;
  logic [BUF_W-1:0]  w_buf_pop;
  logic [BUF_W-1:0]  w_ins;
  logic [BUF_W-1:0]  w_buf_nxt;
  logic [FILL_W-1:0] w_fill_pop;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_pend_nxt;

  always_comb begin
    w_ready = !r_flush_pend && (r_fill <= C_READY_MAX);
    w_valid = (r_fill >= C_WB) || (r_flush_pend && (r_fill != '0));

    w_word = '0;
    for (int b = 0; b < WB; b++) begin
      if (FILL_W'(b) < r_fill) w_word[8*b +: 8] = r_buf[8*b +: 8];
    end

    w_pop  = w_valid && word_ready_i;
    w_push = packet_valid_i && w_ready;

    w_nbytes = len2bytes(int'(packet_len_i));
    if (w_nbytes > PKT_B) w_nbytes = PKT_B;
    w_lmask = lastbyte_mask(int'(packet_len_i));

    w_pkt = '0;
    for (int k = 0; k < PKT_B; k++) begin
      if (k < w_nbytes)
        w_pkt[8*k +: 8] = packet_i[8*k +: 8] & ((k == w_nbytes - 1) ? w_lmask : 8'hFF);
    end

    // Pop first, then the packet lands right after whatever is left.
    w_buf_pop  = w_pop ? (r_buf >> WORD_W) : r_buf;
    w_fill_pop = w_pop ? ((r_fill >= C_WB) ? (r_fill - C_WB) : '0) : r_fill;
    w_ins      = BUF_W'(w_pkt) << {w_fill_pop, 3'b000};

    w_buf_nxt  = w_buf_pop;
    w_fill_nxt = w_fill_pop;
    if (w_push) begin
      w_buf_nxt  = w_buf_pop | w_ins;
      w_fill_nxt = w_fill_pop + FILL_W'(w_nbytes);
    end

    // A flush with nothing left to drain never stays pending.
    w_pend_nxt = (r_flush_pend || flush_i) && (w_fill_nxt != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf        <= '0;
      r_fill       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_buf        <= w_buf_nxt;
      r_fill       <= w_fill_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  assign packet_ready_o = w_ready;
  assign word_valid_o   = w_valid;
  assign word_o         = w_word;
  assign fill_bytes_o   = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_emitter.sv
`default_nettype none
// ============================================================
// tb_trdb_packet_emitter: byte-queue model bench for the trace emitter.
// Rev 1.0
// ============================================================
module tb_trdb_packet_emitter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [127:0] packet_i;
  logic [7:0]   packet_len_i;
  logic         packet_valid_i;
  logic         packet_ready_o;
  logic         flush_i;
  logic [31:0]  word_o;
  logic         word_valid_o;
  logic         word_ready_i;
  logic [4:0]   fill_bytes_o;

  trdb_packet_emitter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .packet_i       (packet_i),
    .packet_len_i   (packet_len_i),
    .packet_valid_i (packet_valid_i),
    .packet_ready_o (packet_ready_o),
    .flush_i        (flush_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .fill_bytes_o   (fill_bytes_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the buffered byte stream as a plain queue.
  byte unsigned mq[$];
  bit           mpend = 1'b0;

  function automatic bit exp_ready();
    return !mpend && (mq.size() <= 16);
  endfunction

  function automatic bit exp_ready_dut();
    return !mpend && (mq.size() <= 4);
  endfunction

  function automatic bit exp_valid();
    return (mq.size() >= 4) || (mpend && mq.size() != 0);
  endfunction

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4 && b < mq.size(); b++) w = w | (32'(mq[b]) << (8 * b));
    return w;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ready", 128'(packet_ready_o), 128'(exp_ready_dut()));
    chk("valid", 128'(word_valid_o), 128'(exp_valid()));
    chk("word",  128'(word_o), 128'(exp_word()));
    chk("fill",  128'(fill_bytes_o), 128'(mq.size()));
  endtask

  // Called at a negedge: check, drive, advance the model, wait one cycle.
  task automatic cycle(input bit pv, input logic [127:0] pkt, input int len,
                       input bit fl, input bit wr);
    bit pop, push;
    int nb, npop;
    byte unsigned bv;
    check_outputs();
    packet_valid_i = pv;
    packet_i       = pkt;
    packet_len_i   = 8'(len);
    flush_i        = fl;
    word_ready_i   = wr;
    pop  = exp_valid() && wr;
    push = pv && exp_ready_dut();
    if (pop) begin
      npop = (mq.size() < 4) ? mq.size() : 4;
      repeat (npop) void'(mq.pop_front());
    end
    if (push) begin
      nb = (len + 7) / 8;
      for (int k = 0; k < nb; k++) begin
        bv = 8'(pkt >> (8 * k));
        if (k == nb - 1 && (len % 8) != 0) bv = bv & 8'((1 << (len % 8)) - 1);
        mq.push_back(bv);
      end
    end
    mpend = (mpend || fl) && (mq.size() != 0);
    @(negedge clk_i);
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() != 0 && guard < 64) begin
      cycle(1'b0, '0, 0, (mq.size() < 4), 1'b1);
      guard++;
    end
    chk("drain_empty", 128'(mq.size()), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] big;
    logic [31:0]  bp [5];
    int idx, guard;

    rst_ni = 1'b0; packet_i = '0; packet_len_i = '0; packet_valid_i = 1'b0;
    flush_i = 1'b0; word_ready_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_ready", 128'(packet_ready_o), 128'(1));
    chk("rst_valid", 128'(word_valid_o), 128'(0));
    chk("rst_fill",  128'(fill_bytes_o), 128'(0));
    chk("rst_word",  128'(word_o), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single full word.
    cycle(1'b1, 128'hDDCCBBAA, 32, 1'b0, 1'b0);
    chk("w32_word",  128'(word_o), 128'h DDCCBBAA);
    chk("w32_valid", 128'(word_valid_o), 128'(1));
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    chk("w32_popfill", 128'(fill_bytes_o), 128'(0));

    // Two odd-length packets packed densely.
    cycle(1'b1, 128'hFABC, 12, 1'b0, 1'b0);
    cycle(1'b1, 128'hF12345, 20, 1'b0, 1'b0);
    chk("pack_word", 128'(word_o), 128'h23450ABC);
    chk("pack_fill", 128'(fill_bytes_o), 128'(5));
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    chk("pack_rem_valid", 128'(word_valid_o), 128'(0));
    cycle(1'b0, '0, 0, 1'b1, 1'b0);
    chk("pack_flush_word", 128'(word_o), 128'h00000001);
    cycle(1'b0, '0, 0, 1'b0, 1'b1);

    // Flush of a single byte.
    cycle(1'b1, 128'h5A, 8, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 1'b1, 1'b0);
    chk("fl_word",  128'(word_o), 128'h0000005A);
    chk("fl_valid", 128'(word_valid_o), 128'(1));
    chk("fl_ready", 128'(packet_ready_o), 128'(0));
    cycle(1'b1, 128'h77, 8, 1'b0, 1'b0);
    chk("fl_ready_held", 128'(packet_ready_o), 128'(0));
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    chk("fl_ready_back", 128'(packet_ready_o), 128'(1));
    chk("fl_fill", 128'(fill_bytes_o), 128'(0));

    // Backpressure.
    for (int j = 0; j < 5; j++) bp[j] = 32'h11111111 * (j + 1);
    for (int j = 0; j < 5; j++) cycle(1'b1, 128'(bp[j]), 32, 1'b0, 1'b0);
    chk("bp_fill",  128'(fill_bytes_o), 128'(8));
    chk("bp_word",  128'(word_o), 128'(bp[0]));
    chk("bp_ready", 128'(packet_ready_o), 128'(0));
    idx = 2; guard = 0;
    while (idx < 5 && guard < 40) begin
      if (exp_ready_dut()) begin
        cycle(1'b1, 128'(bp[idx]), 32, 1'b0, 1'b1);
        idx++;
      end else begin
        cycle(1'b0, '0, 0, 1'b0, 1'b1);
      end
      guard++;
    end
    chk("bp_all_sent", 128'(idx), 128'(5));
    drain();

    // Zero-length push, then pop and full-width push together.
    cycle(1'b1, 128'h04030201, 32, 1'b0, 1'b0);
    cycle(1'b1, 128'hFFEEDDCC, 0, 1'b0, 1'b0);
    chk("len0_fill", 128'(fill_bytes_o), 128'(4));
    big = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    cycle(1'b1, big, 128, 1'b0, 1'b1);
    chk("pp_fill", 128'(fill_bytes_o), 128'(16));
    chk("pp_word", 128'(word_o), 128'(big[31:0]));
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 128 : int'($urandom_range(0, 128));
      cycle(($urandom_range(0, 3) != 0),
            {$urandom, $urandom, $urandom, $urandom}, len,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end
    drain();

    // Asynchronous reset with data in flight.
    cycle(1'b1, 128'hCAFEBABE, 32, 1'b0, 1'b0);
    cycle(1'b1, 128'h1122334455667788, 64, 1'b0, 1'b0);
    chk("mid_fill_pre", 128'(fill_bytes_o), 128'(12));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_fill",  128'(fill_bytes_o), 128'(0));
    chk("mid_rst_valid", 128'(word_valid_o), 128'(0));
    chk("mid_rst_ready", 128'(packet_ready_o), 128'(1));
    mq.delete();
    mpend = 1'b0;
    packet_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    cycle(1'b1, 128'h0BADF00D, 32, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
